// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding request responder backed by a
// word-addressed data memory and a hardware stack.
//
// State table
//   IDLE | ready for a request; req_ready high outside reset
//   WAIT | request captured, counting down the fixed access latency
//   RESP | one-cycle response pulse; access performed on the entering edge
//
// Ports
//   clk        : clock, rising-edge
//   reset      : synchronous active-high reset
//   req_valid  : request present
//   req_ready  : request can be accepted (IDLE and not in reset)
//   req_op     : 00 read, 01 write, 10 push, 11 pop
//   req_addr   : byte address for read/write
//   req_wdata  : write / push data
//   rsp_valid  : one-cycle response strobe
//   rsp_rdata  : read / pop data, zero outside the response cycle
//   rsp_err    : out-of-range, stack overflow or underflow
//   sp         : stack occupancy
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int STACK_DEPTH = 32,
  parameter int LAT         = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    req_op,
  input  logic [31:0]                   req_addr,
  input  logic [31:0]                   req_wdata,
  output logic                          rsp_valid,
  output logic [31:0]                   rsp_rdata,
  output logic                          rsp_err,
  output logic [$clog2(STACK_DEPTH):0]  sp
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SW  = $clog2(STACK_DEPTH);
  localparam int SPW = SW + 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_PUSH  = 2'b10;
  localparam logic [1:0] OP_POP   = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [1:0]  op_q;
  logic [31:0] addr_q, wdata_q;

  logic        accept;
  logic        access;
  logic [1:0]  acc_op;
  logic [31:0] acc_addr, acc_wdata;
  logic        in_range;
  logic [AW-1:0] idx;
  logic [SPW-1:0] sp_m1, sp_next;
  logic [31:0] rdata_next;
  logic        err_next;
  logic        mem_we, stack_we;

  logic [31:0] mem   [DEPTH];
  logic [31:0] stack [STACK_DEPTH];

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^acc_addr[1:0];

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // With LAT==0 the access happens on the accept edge itself, so the
  // request fields come straight from the ports rather than the captures.
  assign acc_op    = (state == IDLE) ? req_op    : op_q;
  assign acc_addr  = (state == IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state == IDLE) ? req_wdata : wdata_q;

  assign in_range = (acc_addr[31:AW+2] == '0);
  assign idx      = acc_addr[AW+1:2];
  assign sp_m1    = sp - SPW'(1);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    access     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LAT == 0) begin
            state_next = RESP;
            access     = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(LAT);
          end
        end
      end
      WAIT: begin
        // The counter sits at zero for one cycle before RESP, giving
        // LAT+1 edges from accept to the response.
        if (cnt == 4'd0) begin
          state_next = RESP;
          access     = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rdata_next = '0;
    err_next   = 1'b0;
    mem_we     = 1'b0;
    stack_we   = 1'b0;
    sp_next    = sp;
    if (access) begin
      case (acc_op)
        OP_READ: begin
          if (in_range) rdata_next = mem[idx];
          else          err_next   = 1'b1;
        end
        OP_WRITE: begin
          if (in_range) mem_we   = 1'b1;
          else          err_next = 1'b1;
        end
        OP_PUSH: begin
          if (sp == SP_FULL) begin
            err_next = 1'b1;
          end else begin
            stack_we = 1'b1;
            sp_next  = sp + SPW'(1);
          end
        end
        default: begin
          if (sp == '0) begin
            err_next = 1'b1;
          end else begin
            rdata_next = stack[sp_m1[SW-1:0]];
            sp_next    = sp_m1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sp        <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      sp        <= sp_next;
      rsp_valid <= access;
      rsp_rdata <= rdata_next;
      rsp_err   <= err_next;
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Storage is never cleared; reset only blocks an in-flight write.
  always_ff @(posedge clk) begin
    if (!reset && mem_we)   mem[idx]            <= acc_wdata;
    if (!reset && stack_we) stack[sp[SW-1:0]]   <= acc_wdata;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int DEPTH       = 256;
  localparam int STACK_DEPTH = 32;
  localparam logic [1:0] RD = 2'b00, WR = 2'b01, PU = 2'b10, PO = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [5:0]  sp;

  logic        req_valid0, req_ready0;
  logic [1:0]  req_op0;
  logic [31:0] req_addr0, req_wdata0;
  logic        rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;
  logic [5:0]  sp0;

  data_mem_responder #(.DEPTH(DEPTH), .STACK_DEPTH(STACK_DEPTH), .LAT(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .sp(sp)
  );

  data_mem_responder #(.DEPTH(DEPTH), .STACK_DEPTH(STACK_DEPTH), .LAT(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_op(req_op0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .sp(sp0)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_m [int];
  logic [31:0] stk_m [$];
  logic [31:0] got0  [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: word memory as an associative array, stack as a queue.
  task automatic model(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic er);
    int idx;
    bit oor;
    idx = int'((addr / 4) % DEPTH);
    oor = (addr >= 32'(DEPTH * 4));
    rd = '0;
    er = 1'b0;
    case (op)
      RD: if (oor) er = 1'b1; else rd = mem_m[idx];
      WR: if (oor) er = 1'b1; else mem_m[idx] = wdata;
      PU: if (stk_m.size() == STACK_DEPTH) er = 1'b1; else stk_m.push_back(wdata);
      default: if (stk_m.size() == 0) er = 1'b1; else rd = stk_m.pop_back();
    endcase
  endtask

  task automatic xact(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rd, output logic er, output int edges, output logic [5:0] sp_at);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    edges = 0;
    while (!rsp_valid && edges < 40) begin @(negedge clk); edges++; end
    rd = rsp_rdata; er = rsp_err; sp_at = sp;
    @(negedge clk);
    check("pulse_one_cycle", {31'd0, rsp_valid}, 32'd0);
    check("rdata_idle_zero", rsp_rdata, 32'd0);
    check("err_idle_zero", {31'd0, rsp_err}, 32'd0);
  endtask

  task automatic run_a(input string tag, input logic [1:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata);
    logic [31:0] exp_rd, rd;
    logic exp_er, er;
    int edges;
    logic [5:0] sp_at;
    model(op, addr, wdata, exp_rd, exp_er);
    xact(op, addr, wdata, rd, er, edges, sp_at);
    check({tag, "_latency"}, edges, 32'd3);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, {31'd0, er}, {31'd0, exp_er});
    check({tag, "_sp"}, {26'd0, sp_at}, stk_m.size());
  endtask

  // Hold req_valid on the LAT=0 instance and count accepts / responses.
  task automatic burst0(input logic [1:0] op, input int n, input logic [31:0] base);
    int acc, cyc, prev;
    acc = 0; cyc = 0; prev = -1;
    got0.delete();
    while (acc < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      req_valid0 = 1'b1; req_op0 = op; req_wdata0 = base + acc;
      if (rsp_valid0) begin
        check("b2b_ready_low_in_resp", {31'd0, req_ready0}, 32'd0);
        got0.push_back(rsp_rdata0);
      end
      if (req_ready0) begin
        if (prev >= 0) check("b2b_spacing", cyc - prev, 32'd2);
        prev = cyc;
        acc++;
      end
    end
    @(negedge clk);
    req_valid0 = 1'b0;
    if (rsp_valid0) got0.push_back(rsp_rdata0);
    check("b2b_response_count", got0.size(), n);
  endtask

  initial begin
    logic [31:0] base;
    reset = 1'b1;
    req_valid = 1'b0; req_op = RD; req_addr = '0; req_wdata = '0;
    req_valid0 = 1'b0; req_op0 = RD; req_addr0 = '0; req_wdata0 = '0;

    repeat (3) @(negedge clk);
    check("rst_ready_low", {31'd0, req_ready}, 32'd0);
    check("rst_ready0_low", {31'd0, req_ready0}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    check("rst_sp", {26'd0, sp}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);

    run_a("wr_deadbeef", WR, 32'h10, 32'hDEADBEEF);
    run_a("rd_deadbeef", RD, 32'h10, 32'h0);

    run_a("push1", PU, 32'h0, 32'h1);
    run_a("push2", PU, 32'h0, 32'h2);
    run_a("pop_a", PO, 32'h0, 32'h0);
    run_a("pop_b", PO, 32'h0, 32'h0);
    run_a("pop_under", PO, 32'h0, 32'h0);

    for (int i = 0; i < 33; i++) run_a("fill_push", PU, 32'h0, 32'h1000 + 32'(i));
    run_a("pop_after_ovf", PO, 32'h0, 32'h0);

    run_a("wr_word0", WR, 32'h0, 32'h12345678);
    run_a("rd_oor", RD, 32'h400, 32'h0);
    run_a("wr_oor", WR, 32'h400, 32'hBADBAD00);
    run_a("rd_word0", RD, 32'h3, 32'h0);

    run_a("pre_rst_wr", WR, 32'h20, 32'hAAAA0000);
    @(negedge clk);
    req_valid = 1'b1; req_op = WR; req_addr = 32'h20; req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_rst_accepted", {31'd0, req_ready}, 32'd0);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_ready_low", {31'd0, req_ready}, 32'd0);
      check("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    reset = 1'b0;
    stk_m.delete();
    #1;
    check("mid_rst_ready_after", {31'd0, req_ready}, 32'd1);
    check("mid_rst_sp", {26'd0, sp}, 32'd0);
    repeat (4) begin
      @(negedge clk);
      check("mid_rst_still_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    run_a("rd_after_rst", RD, 32'h20, 32'h0);

    base = $urandom;
    burst0(PU, 8, base);
    check("b2b_sp_full", {26'd0, sp0}, 32'd8);
    burst0(PO, 8, 32'h0);
    for (int j = 0; j < 8; j++) check("b2b_pop_data", got0[j], base + 32'(7 - j));
    check("b2b_sp_empty", {26'd0, sp0}, 32'd0);

    for (int k = 0; k < 16; k++) run_a("rand_init", WR, 32'h100 + 32'(4 * k), $urandom);
    for (int t = 0; t < 80; t++) begin
      int sel;
      logic [31:0] a;
      sel = int'($urandom_range(0, 9));
      a = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      case (sel)
        0, 1, 2: run_a("rand_rd", RD, a, $urandom);
        3, 4:    run_a("rand_wr", WR, a, $urandom);
        5: begin
          a = $urandom | (32'h1 << $urandom_range(10, 31));
          run_a("rand_oor", ($urandom_range(0, 1) == 0) ? RD : WR, a, $urandom);
        end
        6, 7:    run_a("rand_push", PU, $urandom, $urandom);
        default: run_a("rand_pop", PO, $urandom, $urandom);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
